// File: rtl/traffic_light_timed.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_timed
// Purpose  : Two-street traffic light controller with tick-timed phases.
//            Main street holds green for at least MAIN_MIN_TICKS and leaves
//            only when the side-street sensor requests service. Side street
//            holds green for at most SIDE_MAX_TICKS, or less if demand drops.
//            Each handover runs a yellow phase, then an all-red clearance
//            phase.
// Ports    : clock      - single clock, rising-edge active
//            clear      - asynchronous active-high reset
//            tick       - one-clock time-base enable from the prescaler
//            x          - side-street vehicle sensor (level)
//            MainStreet - main lamp, RED=0 YELLOW=1 GREEN=2 (registered)
//            SideStreet - side lamp, same encoding (registered)
//            phase      - current state code for debug (registered)
//            ped_req    - pedestrian request (TRAFFIC_PED_EN only)
//            walk       - walk lamp, high exactly during SG (TRAFFIC_PED_EN)
// Options  : `define TRAFFIC_PED_EN adds the pedestrian request/walk feature.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_light_timed #(
  parameter int CNT_W          = 8,
  parameter int MAIN_MIN_TICKS = 10,
  parameter int SIDE_MAX_TICKS = 20,
  parameter int YELLOW_TICKS   = 3,
  parameter int ALLRED_TICKS   = 1
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       tick,
  input  logic       x,
  output logic [1:0] MainStreet,
  output logic [1:0] SideStreet,
  output logic [2:0] phase
`ifdef TRAFFIC_PED_EN
  ,
  input  logic       ped_req,
  output logic       walk
`endif
);

  typedef enum logic [2:0] {
    ST_MG  = 3'd0,
    ST_MY  = 3'd1,
    ST_AR1 = 3'd2,
    ST_SG  = 3'd3,
    ST_SY  = 3'd4,
    ST_AR2 = 3'd5
  } state_t;

  localparam logic [1:0] c_RED    = 2'd0;
  localparam logic [1:0] c_YELLOW = 2'd1;
  localparam logic [1:0] c_GREEN  = 2'd2;

  // Counter load values: a phase of N ticks loads N-1 and leaves on the
  // tick that finds the counter at zero.
  localparam logic [CNT_W-1:0] c_MAIN_LOAD   = CNT_W'(MAIN_MIN_TICKS - 1);
  localparam logic [CNT_W-1:0] c_SIDE_LOAD   = CNT_W'(SIDE_MAX_TICKS - 1);
  localparam logic [CNT_W-1:0] c_YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] c_ALLRED_LOAD = CNT_W'(ALLRED_TICKS - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_cnt_zero;
  logic             w_main_exit;    // request to leave main green
  logic             w_side_demand;  // reason to keep side green
  logic [1:0]       r_main;
  logic [1:0]       r_side;
  logic [2:0]       r_phase;
  logic [1:0]       w_main;
  logic [1:0]       w_side;

  assign w_cnt_zero = (r_cnt == '0);

`ifdef TRAFFIC_PED_EN
  logic r_ped_pending;
  logic r_walk;

  assign w_main_exit   = x | r_ped_pending;
  assign w_side_demand = x | r_ped_pending;

  // Request is sticky until the side phase that serves it begins. A request
  // arriving on the very edge that enters SG is for the next cycle, so the
  // set takes priority over the clear.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_ped_pending <= 1'b0;
      r_walk        <= 1'b0;
    end else begin
      if (ped_req) begin
        r_ped_pending <= 1'b1;
      end else if ((r_state != ST_SG) && (w_next_state == ST_SG)) begin
        r_ped_pending <= 1'b0;
      end
      r_walk <= (w_next_state == ST_SG);
    end
  end

  assign walk = r_walk;
`else
  assign w_main_exit   = x;
  assign w_side_demand = x;
`endif

  // --------------------------------------------------------------------------
  // Next-state and counter logic. Nothing moves without tick, except that
  // an illegal state code recovers to MG on the next edge unconditionally.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_MG: begin
        if (tick) begin
          if (!w_cnt_zero) begin
            w_next_cnt = r_cnt - 1'b1;
          end else if (w_main_exit) begin
            w_next_state = ST_MY;
            w_next_cnt   = c_YELLOW_LOAD;
          end
          // else: minimum green served, counter stays saturated at zero so
          // a later request leaves on its first tick.
        end
      end
      ST_MY: begin
        if (tick) begin
          if (!w_cnt_zero) begin
            w_next_cnt = r_cnt - 1'b1;
          end else begin
            w_next_state = ST_AR1;
            w_next_cnt   = c_ALLRED_LOAD;
          end
        end
      end
      ST_AR1: begin
        if (tick) begin
          if (!w_cnt_zero) begin
            w_next_cnt = r_cnt - 1'b1;
          end else begin
            w_next_state = ST_SG;
            w_next_cnt   = c_SIDE_LOAD;
          end
        end
      end
      ST_SG: begin
        if (tick) begin
          // Leave when demand disappears (early exit) or max green expires.
          if (!w_side_demand || w_cnt_zero) begin
            w_next_state = ST_SY;
            w_next_cnt   = c_YELLOW_LOAD;
          end else begin
            w_next_cnt = r_cnt - 1'b1;
          end
        end
      end
      ST_SY: begin
        if (tick) begin
          if (!w_cnt_zero) begin
            w_next_cnt = r_cnt - 1'b1;
          end else begin
            w_next_state = ST_AR2;
            w_next_cnt   = c_ALLRED_LOAD;
          end
        end
      end
      ST_AR2: begin
        if (tick) begin
          if (!w_cnt_zero) begin
            w_next_cnt = r_cnt - 1'b1;
          end else begin
            w_next_state = ST_MG;
            w_next_cnt   = c_MAIN_LOAD;
          end
        end
      end
      default: begin
        w_next_state = ST_MG;
        w_next_cnt   = c_MAIN_LOAD;
      end
    endcase
  end

  // Lamp decode from the next state so the registered lamps change on the
  // same edge as the state register.
  always_comb begin
    w_main = c_RED;
    w_side = c_RED;
    case (w_next_state)
      ST_MG:   w_main = c_GREEN;
      ST_MY:   w_main = c_YELLOW;
      ST_SG:   w_side = c_GREEN;
      ST_SY:   w_side = c_YELLOW;
      default: begin
        w_main = c_RED;
        w_side = c_RED;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= ST_MG;
      r_cnt   <= c_MAIN_LOAD;
      r_main  <= c_GREEN;
      r_side  <= c_RED;
      r_phase <= 3'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_main  <= w_main;
      r_side  <= w_side;
      r_phase <= w_next_state;
    end
  end

  assign MainStreet = r_main;
  assign SideStreet = r_side;
  assign phase      = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_timed.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_timed
// Purpose  : Scoreboard bench for traffic_light_timed (default build).
//            The driver applies tick/x on the falling edge and queues the
//            phase expected after the following rising edge; the monitor
//            pops and compares phase and both lamps after each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_timed;

  logic       clock;
  logic       clear;
  logic       tick;
  logic       x;
  logic [1:0] MainStreet;
  logic [1:0] SideStreet;
  logic [2:0] phase;

  int checks;
  int errors;
  int step_no;
  logic [2:0] exp_q[$];
  logic [2:0] cur;

  traffic_light_timed dut (
    .clock      (clock),
    .clear      (clear),
    .tick       (tick),
    .x          (x),
    .MainStreet (MainStreet),
    .SideStreet (SideStreet),
    .phase      (phase)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int exp_main(input logic [2:0] ph);
    case (ph)
      3'd0:    return 2;
      3'd1:    return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_side(input logic [2:0] ph);
    case (ph)
      3'd3:    return 2;
      3'd4:    return 1;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare the output state produced by each rising edge.
  always @(posedge clock) begin
    logic [2:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step_no++;
      chk($sformatf("phase[step %0d]", step_no), int'(phase), int'(e));
      chk($sformatf("main[step %0d]", step_no), int'(MainStreet), exp_main(e));
      chk($sformatf("side[step %0d]", step_no), int'(SideStreet), exp_side(e));
    end
  end

  // One clock: drive inputs and queue the phase expected after the edge.
  task automatic step(input logic t, input logic xv, input logic [2:0] ph);
    @(negedge clock);
    tick = t;
    x    = xv;
    exp_q.push_back(ph);
  endtask

  // n tick edges each expecting ph, each preceded by gap idle cycles.
  task automatic seg(input logic [2:0] ph, input int n, input logic xv, input int gap);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) step(1'b0, xv, cur);
      step(1'b1, xv, ph);
      cur = ph;
    end
  endtask

  // Assert clear between edges and check the asynchronous effect at once.
  task automatic pulse_clear(input string tag);
    @(negedge clock);
    tick  = 1'b0;
    clear = 1'b1;
    #1;
    chk({tag, " phase"}, int'(phase), 0);
    chk({tag, " main"}, int'(MainStreet), 2);
    chk({tag, " side"}, int'(SideStreet), 0);
    @(negedge clock);
    clear = 1'b0;
    cur   = 3'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    step_no = 0;
    cur     = 3'd0;
    clear   = 1'b1;
    tick    = 1'b0;
    x       = 1'b0;
    #2;
    chk("reset phase", int'(phase), 0);
    chk("reset main", int'(MainStreet), 2);
    chk("reset side", int'(SideStreet), 0);
    // Clear held across edges with tick active: outputs must not move.
    tick = 1'b1;
    x    = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("held reset phase", int'(phase), 0);
    chk("held reset main", int'(MainStreet), 2);
    @(negedge clock);
    tick  = 1'b0;
    x     = 1'b0;
    clear = 1'b0;

    // 1: no side demand, main green forever.
    seg(3'd0, 60, 1'b0, 0);

    // 2: full cycle with constant demand from reset.
    pulse_clear("clear2");
    seg(3'd0, 9, 1'b1, 0);
    seg(3'd1, 3, 1'b1, 0);
    seg(3'd2, 1, 1'b1, 0);
    seg(3'd3, 20, 1'b1, 0);
    seg(3'd4, 3, 1'b1, 0);
    seg(3'd5, 1, 1'b1, 0);
    seg(3'd0, 10, 1'b1, 0);

    // 3: early side exit after six SG cycles.
    seg(3'd1, 3, 1'b1, 0);
    seg(3'd2, 1, 1'b1, 0);
    seg(3'd3, 6, 1'b1, 0);
    seg(3'd4, 3, 1'b0, 0);
    seg(3'd5, 1, 1'b0, 0);
    seg(3'd0, 10, 1'b0, 0);
    // Saturated main green: x pulse between ticks is ignored.
    step(1'b0, 1'b1, 3'd0);
    step(1'b1, 1'b0, 3'd0);

    // 4: tick every 4th cycle, plus a 7-cycle freeze inside MY.
    seg(3'd1, 1, 1'b1, 3);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 3'd1);
    seg(3'd1, 2, 1'b1, 3);
    seg(3'd2, 1, 1'b1, 3);
    seg(3'd3, 20, 1'b1, 3);
    seg(3'd4, 3, 1'b1, 3);
    seg(3'd5, 1, 1'b1, 3);
    seg(3'd0, 10, 1'b1, 3);

    // 5: asynchronous clear in the middle of SG, then a full main green.
    seg(3'd1, 3, 1'b1, 0);
    seg(3'd2, 1, 1'b1, 0);
    seg(3'd3, 5, 1'b1, 0);
    pulse_clear("clear5");
    seg(3'd0, 9, 1'b1, 0);
    seg(3'd1, 1, 1'b1, 0);

    // Drain the scoreboard within a bounded number of cycles.
    @(negedge clock);
    tick = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
